muldiv_unit: RTL and testbench

Sequential RV32M multiply/divide unit sitting directly upstream of the register file write port. It takes the two source operands read from the register file plus the destination index, iterates for a fixed number of cycles, and presents a 32-bit result with a one-cycle write-enable pulse for the register file's write port. The control path must stall the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit feeding the register file write port.
// Fixed 34-cycle latency: 32 shift-add / restoring-divide steps, a fix-up cycle, a done cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            regwrite_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_r, state_nxt_s;
  logic [4:0]  cnt_r;
  logic [2:0]  f3_r;
  logic [31:0] a_raw_r, mag_a_r, mag_b_r;
  logic [31:0] acc_hi_r, acc_lo_r;
  logic        neg_res_r, neg_rem_r, div_zero_r, ovf_r;
  logic        busy_r, done_r, regwrite_r;
  logic [31:0] result_r;
  logic [4:0]  rd_out_r;

  logic        sign_a_s, sign_b_s, neg_a_s, neg_b_s;
  logic [31:0] mag_a_in_s, mag_b_in_s;
  logic [32:0] mul_sum_s, div_shift_s, div_diff_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s, rem_fix_s, fix_result_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_CALC;
        else       state_nxt_s = S_IDLE;
      end
      S_CALC: begin
        if (cnt_r == 5'd0) state_nxt_s = S_FIX;
        else               state_nxt_s = S_CALC;
      end
      S_FIX:   state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand sign decode and magnitudes at latch time
  always_comb begin
    sign_a_s   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_b_s   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a_s    = sign_a_s & op_a[31];
    neg_b_s    = sign_b_s & op_b[31];
    mag_a_in_s = neg_a_s ? neg32(op_a) : op_a;
    mag_b_in_s = neg_b_s ? neg32(op_b) : op_b;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mag_a_r} : 33'd0);
    div_shift_s = {acc_hi_r, acc_lo_r[31]};
    div_diff_s  = div_shift_s - {1'b0, mag_b_r};
  end

  // Sign fix-up and special-case selection
  always_comb begin
    prod_fix_s   = neg_res_r ? (~{acc_hi_r, acc_lo_r} + 64'd1) : {acc_hi_r, acc_lo_r};
    quot_fix_s   = neg_res_r ? neg32(acc_lo_r) : acc_lo_r;
    rem_fix_s    = neg_rem_r ? neg32(acc_hi_r) : acc_hi_r;
    fix_result_s = 32'd0;
    case (f3_r)
      3'b000:                 fix_result_s = prod_fix_s[31:0];
      3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[63:32];
      3'b100: fix_result_s = div_zero_r ? 32'hFFFF_FFFF : (ovf_r ? 32'h8000_0000 : quot_fix_s);
      3'b101: fix_result_s = div_zero_r ? 32'hFFFF_FFFF : quot_fix_s;
      3'b110: fix_result_s = div_zero_r ? a_raw_r : (ovf_r ? 32'd0 : rem_fix_s);
      3'b111: fix_result_s = div_zero_r ? a_raw_r : rem_fix_s;
      default: fix_result_s = 32'd0;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 5'd0;
      f3_r       <= 3'd0;
      a_raw_r    <= 32'd0;
      mag_a_r    <= 32'd0;
      mag_b_r    <= 32'd0;
      acc_hi_r   <= 32'd0;
      acc_lo_r   <= 32'd0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      regwrite_r <= 1'b0;
      result_r   <= 32'd0;
      rd_out_r   <= 5'd0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != S_IDLE);
      done_r     <= (state_r == S_FIX);
      regwrite_r <= (state_r == S_FIX);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r      <= 5'd31;
            f3_r       <= funct3;
            a_raw_r    <= op_a;
            mag_a_r    <= mag_a_in_s;
            mag_b_r    <= mag_b_in_s;
            acc_hi_r   <= 32'd0;
            // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend out.
            acc_lo_r   <= funct3[2] ? mag_a_in_s : mag_b_in_s;
            neg_res_r  <= neg_a_s ^ neg_b_s;
            neg_rem_r  <= neg_a_s;
            div_zero_r <= (op_b == 32'd0);
            ovf_r      <= sign_a_s && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
            rd_out_r   <= rd_out_r;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_CALC: begin
          if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
          else               cnt_r <= cnt_r;
          if (f3_r[2]) begin
            if (!div_diff_s[32]) begin
              acc_hi_r <= div_diff_s[31:0];
              acc_lo_r <= {acc_lo_r[30:0], 1'b1};
            end else begin
              acc_hi_r <= div_shift_s[31:0];
              acc_lo_r <= {acc_lo_r[30:0], 1'b0};
            end
          end else begin
            acc_hi_r <= mul_sum_s[32:1];
            acc_lo_r <= {mul_sum_s[0], acc_lo_r[31:1]};
          end
        end
        S_FIX: begin
          result_r <= fix_result_s;
          rd_out_r <= rd_latch_s();
        end
        S_DONE:  cnt_r <= cnt_r;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Destination index captured alongside the operands
  logic [4:0] rd_lat_r;
  always_ff @(posedge clk) begin
    if (rst)                          rd_lat_r <= 5'd0;
    else if (state_r == S_IDLE && start) rd_lat_r <= rd_in;
    else                              rd_lat_r <= rd_lat_r;
  end

  function automatic logic [4:0] rd_latch_s();
    return rd_lat_r;
  endfunction

  assign busy         = busy_r;
  assign done         = done_r;
  assign regwrite_out = regwrite_r;
  assign result       = result_r;
  assign rd_out       = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random scoreboard bench for muldiv_unit: latency, results, ignored starts, mid-op reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, regwrite_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t scoreboard[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .regwrite_out(regwrite_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, ub;
    logic [63:0]        p;
    logic signed [31:0] as32, bs32, q;
    sa   = $signed({{32{a[31]}}, a});
    sbv  = $signed({{32{b[31]}}, b});
    ub   = $signed({32'd0, b});
    as32 = $signed(a);
    bs32 = $signed(b);
    case (f)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = as32 / bs32; return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = as32 % bs32; return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // mode 0: normal, 1: extra starts at edges k+10/k+34/k+35, 2: reset at edge k+20
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int mode);
    int   busy_n, done_n, done_at;
    exp_t e;
    busy_n = 0; done_n = 0; done_at = 0;
    if (mode != 2) scoreboard.push_back({exp, rd});
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      start = 1'b0;
      op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      if (mode == 2 && c == 20) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        rst = 1'b0;
      end
      if (busy) busy_n++;
      check("regwrite_eq_done", 32'(regwrite_out), 32'(done));
      if (done) begin
        done_n++;
        done_at = c;
        checks++;
        assert (scoreboard.size() > 0) else begin
          errors++;
          $error("FAIL sb_empty: got done with %0d pending expected 1", scoreboard.size());
        end
        if (scoreboard.size() > 0) begin
          e = scoreboard.pop_front();
          check("result", result, e.res);
          check("rd_out", 32'(rd_out), 32'(e.rd));
        end
      end
      if (mode == 1 && (c == 9 || c == 33 || c == 34)) begin
        start = 1'b1; funct3 = 3'd4; op_a = 32'd999; op_b = 32'd3; rd_in = 5'd31;
      end
      if (mode == 2 && c == 19) rst = 1'b1;
    end
    if (mode == 2) begin
      check("rst_busy_cycles", 32'(busy_n), 32'd19);
      check("rst_no_done", 32'(done_n), 32'd0);
      check("rst_hold_result", result, 32'd0);
    end else begin
      check("busy_cycles", 32'(busy_n), 32'd34);
      check("done_count", 32'(done_n), 32'd1);
      check("done_latency", 32'(done_at), 32'd34);
      if (mode == 1) begin
        check("ignored_start_result", result, exp);
        check("ignored_start_rd", 32'(rd_out), 32'(rd));
      end
    end
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_regwrite", 32'(regwrite_out), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7,          32'd6,          5'd5,  32'h0000_002A, 0);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'h0000_0002,  5'd8,  32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100,        32'd7,          5'd11, 32'd14,        0);
    run_op(3'd7, 32'd100,        32'd7,          5'd12, 32'd2,         0);
    run_op(3'd4, 32'h1234_5678,  32'd0,          5'd13, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h1234_5678,  32'd0,          5'd14, 32'h1234_5678, 0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h0000_0000, 0);
    run_op(3'd0, 32'd3,          32'd5,          5'd0,  32'd15,        0);
    run_op(3'd0, 32'd7,          32'd6,          5'd3,  32'h0000_002A, 1);
    run_op(3'd5, 32'd1000,       32'd3,          5'd4,  32'd0,         2);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_vs_start_busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op(rf, ra, rb, 5'(i + 17), ref_model(rf, ra, rb), 0);
    end

    check("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
